// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, all-zero lock-up recovery,
// period-wrap pulse and a step counter measured from the current start value.
module lfsr_gen #(
   parameter int unsigned         WIDTH  = 8,
   parameter logic [WIDTH-1:0]    TAPS   = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0]    SEED   = WIDTH'(1),
   parameter bit                  GALOIS = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             serial_out,
   output logic             wrap,
   output logic             lockup,
   output logic [WIDTH-1:0] steps
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // Reject illegal parameterisations at elaboration.
   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be within 3..32");
   end
   if (SEED == ZERO) begin : g_bad_seed
      $error("lfsr_gen: SEED must be nonzero");
   end

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] steps_q, steps_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;

   logic             fib_fb;
   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] next_state;

   // Single-step successor of the current state in both forms.
   always_comb begin
      fib_fb     = ^(state_q & TAPS);
      fib_next   = {state_q[WIDTH-2:0], fib_fb};
      gal_next   = (state_q >> 1) ^ (state_q[0] ? TAPS : ZERO);
      next_state = GALOIS ? gal_next : fib_next;
   end

   // Next-state selection: set > load > en > hold.
   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      steps_d  = steps_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;

      if (set) begin
         state_d = SEED;
         start_d = SEED;
         steps_d = ZERO;
      end else if (load) begin
         steps_d = ZERO;
         if (seed_in != ZERO) begin
            state_d = seed_in;
            start_d = seed_in;
         end else begin
            state_d  = SEED;
            start_d  = SEED;
            lockup_d = 1'b1;
         end
      end else if (en) begin
         if (state_q == ZERO) begin
            // All-zero is a fixed point of both forms; reseed to escape it.
            state_d  = SEED;
            start_d  = SEED;
            steps_d  = ZERO;
            lockup_d = 1'b1;
         end else begin
            state_d = next_state;
            if (next_state == start_q) begin
               wrap_d  = 1'b1;
               steps_d = ZERO;
            end else begin
               steps_d = steps_q + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= SEED;
         start_q  <= SEED;
         steps_q  <= ZERO;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         steps_q  <= steps_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   assign out        = state_q;
   assign steps      = steps_q;
   assign wrap       = wrap_q;
   assign lockup     = lockup_q;
   // Serial tap is the bit about to leave the register in each form.
   assign serial_out = GALOIS ? state_q[0] : state_q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: 4-bit Fibonacci, 4-bit Galois and default 8-bit instances.
module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       f_set, f_load, f_en, g_set, g_load, g_en, d_set, d_load, d_en;
   logic [3:0] f_seed, g_seed;
   logic [7:0] d_seed;
   logic [3:0] f_out, f_steps, g_out, g_steps;
   logic [7:0] d_out, d_steps;
   logic       f_ser, f_wrap, f_lock, g_ser, g_wrap, g_lock, d_ser, d_wrap, d_lock;

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .GALOIS(1'b0)) u_fib (
      .clk(clk), .rst(rst_n), .set(f_set), .load(f_load), .seed_in(f_seed), .en(f_en),
      .out(f_out), .serial_out(f_ser), .wrap(f_wrap), .lockup(f_lock), .steps(f_steps));

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .GALOIS(1'b1)) u_gal (
      .clk(clk), .rst(rst_n), .set(g_set), .load(g_load), .seed_in(g_seed), .en(g_en),
      .out(g_out), .serial_out(g_ser), .wrap(g_wrap), .lockup(g_lock), .steps(g_steps));

   lfsr_gen u_d8 (
      .clk(clk), .rst(rst_n), .set(d_set), .load(d_load), .seed_in(d_seed), .en(d_en),
      .out(d_out), .serial_out(d_ser), .wrap(d_wrap), .lockup(d_lock), .steps(d_steps));

   typedef struct {
      logic [7:0] out;
      logic [7:0] steps;
      logic       wrap;
      logic       lockup;
   } obs_t;

   obs_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] fib_tbl [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                                4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
   logic [3:0] gal_tbl [15] = '{4'b1100, 4'b0110, 4'b0011, 4'b1101, 4'b1010, 4'b0101, 4'b1110,
                                4'b0111, 4'b1111, 4'b1011, 4'b1001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

   function automatic obs_t mk(input logic [7:0] o, input logic [7:0] s, input logic w, input logic l);
      obs_t r;
      r.out = o; r.steps = s; r.wrap = w; r.lockup = l;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int inst, input logic s, input logic l, input logic [7:0] sd, input logic e);
      case (inst)
         0:       begin f_set = s; f_load = l; f_seed = sd[3:0]; f_en = e; end
         1:       begin g_set = s; g_load = l; g_seed = sd[3:0]; g_en = e; end
         default: begin d_set = s; d_load = l; d_seed = sd;      d_en = e; end
      endcase
   endtask

   task automatic sample(input int inst, output obs_t o, output logic ser, output logic ser_exp);
      case (inst)
         0:       begin o = mk(8'(f_out), 8'(f_steps), f_wrap, f_lock); ser = f_ser; ser_exp = f_out[3]; end
         1:       begin o = mk(8'(g_out), 8'(g_steps), g_wrap, g_lock); ser = g_ser; ser_exp = g_out[0]; end
         default: begin o = mk(d_out, d_steps, d_wrap, d_lock);         ser = d_ser; ser_exp = d_out[7]; end
      endcase
   endtask

   // Pop the oldest expectation and compare it against the instance outputs.
   task automatic compare(input int inst, input string tag, output obs_t got);
      obs_t exp;
      logic ser, ser_exp;
      sample(inst, got, ser, ser_exp);
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
         exp = sb_q.pop_front();
         chk({tag, ".out"},    32'(got.out),    32'(exp.out));
         chk({tag, ".steps"},  32'(got.steps),  32'(exp.steps));
         chk({tag, ".wrap"},   32'(got.wrap),   32'(exp.wrap));
         chk({tag, ".lockup"}, 32'(got.lockup), 32'(exp.lockup));
         chk({tag, ".serial"}, 32'(ser),        32'(ser_exp));
      end
   endtask

   task automatic cycle(input int inst, input string tag, input logic s, input logic l,
                        input logic [7:0] sd, input logic e, input obs_t exp, output obs_t got);
      drive(inst, s, l, sd, e);
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      compare(inst, tag, got);
      @(negedge clk);
   endtask

   task automatic peek(input int inst, input string tag, input obs_t exp);
      obs_t got;
      sb_q.push_back(exp);
      compare(inst, tag, got);
   endtask

   initial begin
      obs_t       got;
      logic [7:0] m, nxt, ms;
      logic       w;
      bit         seen [256];
      int         dup, zeros, wraps, maxs, distinct;

      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
      drive(1, 1'b0, 1'b0, 8'h00, 1'b1);
      drive(2, 1'b0, 1'b0, 8'h00, 1'b1);
      @(negedge clk);

      // Reset held with en high and clock running.
      for (int i = 0; i < 3; i++) cycle(0, "reset_fib", 1'b0, 1'b0, 8'h00, 1'b1, mk(8'h01, 8'h00, 1'b0, 1'b0), got);
      peek(1, "reset_gal", mk(8'h01, 8'h00, 1'b0, 1'b0));
      peek(2, "reset_d8",  mk(8'h01, 8'h00, 1'b0, 1'b0));
      drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(2, 1'b0, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++)
         cycle(0, "fib_seq", 1'b0, 1'b0, 8'h00, 1'b1,
               mk(8'(fib_tbl[i]), (i == 14) ? 8'h00 : 8'(i + 1), i == 14, 1'b0), got);
      drive(0, 1'b0, 1'b0, 8'h00, 1'b0);

      for (int i = 0; i < 15; i++)
         cycle(1, "gal_seq", 1'b0, 1'b0, 8'h00, 1'b1,
               mk(8'(gal_tbl[i]), (i == 14) ? 8'h00 : 8'(i + 1), i == 14, 1'b0), got);
      drive(1, 1'b0, 1'b0, 8'h00, 1'b0);

      // Runtime seed load and enable gating; 1010 sits at fib_tbl[6].
      cycle(0, "load_1010", 1'b0, 1'b1, 8'h0A, 1'b0, mk(8'h0A, 8'h00, 1'b0, 1'b0), got);
      cycle(0, "gate_en1",  1'b0, 1'b0, 8'h00, 1'b1, mk(8'h05, 8'h01, 1'b0, 1'b0), got);
      cycle(0, "gate_en0",  1'b0, 1'b0, 8'h00, 1'b0, mk(8'h05, 8'h01, 1'b0, 1'b0), got);
      cycle(0, "gate_en1b", 1'b0, 1'b0, 8'h00, 1'b1, mk(8'h0B, 8'h02, 1'b0, 1'b0), got);
      for (int n = 3; n <= 15; n++)
         cycle(0, "load_run", 1'b0, 1'b0, 8'h00, 1'b1,
               mk(8'(fib_tbl[(6 + n) % 15]), (n == 15) ? 8'h00 : 8'(n), n == 15, 1'b0), got);

      // Zero seed load falls back to SEED with a lockup pulse.
      cycle(0, "load_zero", 1'b0, 1'b1, 8'h00, 1'b0, mk(8'h01, 8'h00, 1'b0, 1'b1), got);
      cycle(0, "lock_clr",  1'b0, 1'b0, 8'h00, 1'b0, mk(8'h01, 8'h00, 1'b0, 1'b0), got);

      // Upset the state to all-zero, then step.
      cycle(0, "pre_upset", 1'b0, 1'b0, 8'h00, 1'b1, mk(8'h02, 8'h01, 1'b0, 1'b0), got);
      drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
      force u_fib.state_q = 4'b0000;
      #1;
      peek(0, "upset_zero", mk(8'h00, 8'h01, 1'b0, 1'b0));
      release u_fib.state_q;
      cycle(0, "upset_en",  1'b0, 1'b0, 8'h00, 1'b1, mk(8'h01, 8'h00, 1'b0, 1'b1), got);
      cycle(0, "upset_nxt", 1'b0, 1'b0, 8'h00, 1'b1, mk(8'h02, 8'h01, 1'b0, 1'b0), got);

      // Priority: set over load, load over en.
      cycle(0, "set_load",  1'b1, 1'b1, 8'h06, 1'b0, mk(8'h01, 8'h00, 1'b0, 1'b0), got);
      cycle(0, "post_set",  1'b0, 1'b0, 8'h00, 1'b1, mk(8'h02, 8'h01, 1'b0, 1'b0), got);
      cycle(0, "load_en",   1'b0, 1'b1, 8'h06, 1'b1, mk(8'h06, 8'h00, 1'b0, 1'b0), got);
      cycle(0, "post_load", 1'b0, 1'b0, 8'h00, 1'b1, mk(8'h0D, 8'h01, 1'b0, 1'b0), got);

      // Asynchronous reset between edges.
      drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      peek(0, "async_rst", mk(8'h01, 8'h00, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      peek(0, "rst_held", mk(8'h01, 8'h00, 1'b0, 1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, "first_step", 1'b0, 1'b0, 8'h00, 1'b1, mk(8'h02, 8'h01, 1'b0, 1'b0), got);
      drive(0, 1'b0, 1'b0, 8'h00, 1'b0);

      // Default 8-bit instance: full maximal-length period.
      m = 8'h01; ms = 8'h00;
      dup = 0; zeros = 0; wraps = 0; maxs = 0;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      for (int i = 0; i < 255; i++) begin
         nxt = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
         w   = (nxt == 8'h01);
         ms  = w ? 8'h00 : ms + 8'h01;
         cycle(2, "d8_step", 1'b0, 1'b0, 8'h00, 1'b1, mk(nxt, ms, w, 1'b0), got);
         if (got.out == 8'h00) zeros++;
         if (seen[got.out]) dup++;
         seen[got.out] = 1'b1;
         if (got.wrap) wraps++;
         if (int'(got.steps) > maxs) maxs = int'(got.steps);
         m = nxt;
      end
      distinct = 0;
      for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
      chk("d8_distinct", 32'(distinct), 32'(255));
      chk("d8_dups",     32'(dup),      32'(0));
      chk("d8_zeros",    32'(zeros),    32'(0));
      chk("d8_wraps",    32'(wraps),    32'(1));
      chk("d8_maxsteps", 32'(maxs),     32'(254));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
